// File: rtl/xosera_pkg.sv
// Owner tags shared across the Xosera core.
// The VRAM arbiter uses them to steer returned read data to its requester.
package xosera_pkg;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VGEN = 2'd1,
    TAG_HOST = 2'd2,
    TAG_BLIT = 2'd3
  } tag_t;

  localparam int VRAM_AW = 16;
  localparam int VRAM_DW = 16;

  // Decodes a tag into {vgen, host, blit} read-valid strobes.
  function automatic logic [2:0] tag_to_valid(input tag_t tag);
    logic [2:0] v;
    v = 3'b000;
    case (tag)
      TAG_VGEN: v = 3'b100;
      TAG_HOST: v = 3'b010;
      TAG_BLIT: v = 3'b001;
      default:  v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vram_arb_if.sv
// Requester and VRAM-side signals of the VRAM arbiter.
// slave = arbiter view, master = requesters plus the VRAM instance.
interface vram_arb_if;
  import xosera_pkg::*;

  logic               vgen_sel;
  logic [VRAM_AW-1:0] vgen_addr;
  logic               vgen_rd_valid;

  logic               host_req;
  logic               host_wr;
  logic [VRAM_AW-1:0] host_addr;
  logic [VRAM_DW-1:0] host_wr_data;
  logic               host_ack;
  logic               host_rd_valid;

  logic               blit_req;
  logic               blit_wr;
  logic [VRAM_AW-1:0] blit_addr;
  logic [VRAM_DW-1:0] blit_wr_data;
  logic               blit_ack;
  logic               blit_rd_valid;

  logic [VRAM_DW-1:0] rd_data;

  logic               vram_sel;
  logic               vram_wr;
  logic [VRAM_AW-1:0] vram_addr;
  logic [VRAM_DW-1:0] vram_wr_data;
  logic [VRAM_DW-1:0] vram_data_out;

  modport slave (
    input  vgen_sel, vgen_addr,
    input  host_req, host_wr, host_addr, host_wr_data,
    input  blit_req, blit_wr, blit_addr, blit_wr_data,
    input  vram_data_out,
    output vgen_rd_valid, host_ack, host_rd_valid, blit_ack, blit_rd_valid,
    output rd_data, vram_sel, vram_wr, vram_addr, vram_wr_data
  );

  modport master (
    output vgen_sel, vgen_addr,
    output host_req, host_wr, host_addr, host_wr_data,
    output blit_req, blit_wr, blit_addr, blit_wr_data,
    output vram_data_out,
    input  vgen_rd_valid, host_ack, host_rd_valid, blit_ack, blit_rd_valid,
    input  rd_data, vram_sel, vram_wr, vram_addr, vram_wr_data
  );

endinterface

// File: rtl/vram_arb.sv
// Single-port VRAM arbiter: video > starved blit > host > blit, one registered
// command per cycle, read data returned two cycles after the accept.
module vram_arb
  import xosera_pkg::*;
#(
  parameter int BLIT_STARVE_MAX = 8
) (
  input  logic     clk,
  input  logic     reset_n,
  vram_arb_if.slave bus
);

  localparam int CNT_W = $clog2(BLIT_STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(BLIT_STARVE_MAX);

  tag_t               grant;
  logic               blit_starved;

  logic               sel_q,   sel_d;
  logic               wr_q,    wr_d;
  logic [VRAM_AW-1:0] addr_q,  addr_d;
  logic [VRAM_DW-1:0] wdata_q, wdata_d;
  tag_t               tag1_q,  tag1_d;
  tag_t               tag2_q,  tag2_d;
  logic [CNT_W-1:0]   starve_q, starve_d;
  logic [2:0]         rd_valid;

  assign blit_starved = (starve_q == STARVE_MAX);

  always_comb begin
    grant = TAG_NONE;
    if (bus.vgen_sel) begin
      grant = TAG_VGEN;
    end else if (blit_starved && bus.blit_req) begin
      grant = TAG_BLIT;
    end else if (bus.host_req) begin
      grant = TAG_HOST;
    end else if (bus.blit_req) begin
      grant = TAG_BLIT;
    end
  end

  assign bus.host_ack = (grant == TAG_HOST);
  assign bus.blit_ack = (grant == TAG_BLIT);

  // Idle cycles keep address/data stable so the VRAM port does not toggle.
  always_comb begin
    sel_d   = (grant != TAG_NONE);
    wr_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (grant)
      TAG_VGEN: begin
        addr_d = bus.vgen_addr;
      end
      TAG_HOST: begin
        wr_d    = bus.host_wr;
        addr_d  = bus.host_addr;
        wdata_d = bus.host_wr_data;
      end
      TAG_BLIT: begin
        wr_d    = bus.blit_wr;
        addr_d  = bus.blit_addr;
        wdata_d = bus.blit_wr_data;
      end
      default: ;
    endcase
  end

  // Only reads carry an owner tag; writes return nothing.
  always_comb begin
    tag1_d = (sel_d && !wr_d) ? grant : TAG_NONE;
    tag2_d = tag1_q;
  end

  always_comb begin
    starve_d = '0;
    if (bus.blit_req && !bus.blit_ack) begin
      starve_d = blit_starved ? starve_q : starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      tag1_q   <= TAG_NONE;
      tag2_q   <= TAG_NONE;
      starve_q <= '0;
    end else begin
      sel_q    <= sel_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      tag1_q   <= tag1_d;
      tag2_q   <= tag2_d;
      starve_q <= starve_d;
    end
  end

  assign bus.vram_sel     = sel_q;
  assign bus.vram_wr      = wr_q;
  assign bus.vram_addr    = addr_q;
  assign bus.vram_wr_data = wdata_q;

  assign rd_valid          = tag_to_valid(tag2_q);
  assign bus.vgen_rd_valid = rd_valid[2];
  assign bus.host_rd_valid = rd_valid[1];
  assign bus.blit_rd_valid = rd_valid[0];
  assign bus.rd_data       = bus.vram_data_out;

endmodule

// File: tb/tb_vram_arb.sv
// Self-checking bench for vram_arb: VRAM model, reference memory and a
// scoreboard of expected read returns keyed by due cycle.
module tb_vram_arb;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vram_arb_if bus();

  vram_arb #(.BLIT_STARVE_MAX(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [2:0]  valid;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  bit   [15:0] vram_mem[0:65535];
  bit   [15:0] ref_mem[0:65535];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.vram_sel) begin
      if (bus.vram_wr) vram_mem[bus.vram_addr] <= bus.vram_wr_data;
      else             bus.vram_data_out <= vram_mem[bus.vram_addr];
    end
  end

  // Read-return monitor: every cycle either the due entry matches or nothing is valid.
  always @(negedge clk) begin
    logic [2:0] act;
    act = {bus.vgen_rd_valid, bus.host_rd_valid, bus.blit_rd_valid};
    while (sb.size() > 0 && sb[0].due < cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL rd_missing cycle %0d: expected valid %b data %h never seen", cyc, sb[0].valid, sb[0].data);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      vectors++;
      if (act !== sb[0].valid || bus.rd_data !== sb[0].data) begin
        miscompares++;
        $display("FAIL rd_return cycle %0d: got valid %b data %h, want valid %b data %h", cyc, act, bus.rd_data, sb[0].valid, sb[0].data);
      end
      void'(sb.pop_front());
    end else begin
      vectors++;
      if (act !== 3'b000) begin
        miscompares++;
        $display("FAIL rd_spurious cycle %0d: got valid %b, want 000", cyc, act);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit vs, input bit [15:0] va,
                        input bit hr, input bit hw, input bit [15:0] ha, input bit [15:0] hd,
                        input bit br, input bit bw, input bit [15:0] ba, input bit [15:0] bd);
    bus.vgen_sel = vs;  bus.vgen_addr = va;
    bus.host_req = hr;  bus.host_wr = hw;  bus.host_addr = ha;  bus.host_wr_data = hd;
    bus.blit_req = br;  bus.blit_wr = bw;  bus.blit_addr = ba;  bus.blit_wr_data = bd;
  endtask

  task automatic sb_push(input logic [2:0] valid, input logic [15:0] addr);
    exp_t e;
    e.valid = valid;
    e.data  = ref_mem[addr];
    e.due   = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    @(negedge clk);
    vectors++;
    if ({bus.vram_sel, bus.vram_wr, bus.vram_addr, bus.vram_wr_data} !== 34'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got sel %b wr %b addr %h wdata %h, want all 0", bus.vram_sel, bus.vram_wr, bus.vram_addr, bus.vram_wr_data);
    end
    tick();
    reset_n = 1'b1;
    $display("reset released at cycle %0d", cyc);
    tick();
  endtask

  task automatic test_host_read();
    set_in(0, 0, 1, 0, 16'h1234, 0, 0, 0, 0, 0);
    @(negedge clk);
    vectors++;
    if (bus.host_ack !== 1'b1 || bus.blit_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL host_read_ack: got host %b blit %b, want 1 0", bus.host_ack, bus.blit_ack);
    end
    sb_push(3'b010, 16'h1234);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    vectors++;
    if (bus.vram_sel !== 1'b1 || bus.vram_wr !== 1'b0 || bus.vram_addr !== 16'h1234) begin
      miscompares++;
      $display("FAIL host_read_cmd: got sel %b wr %b addr %h, want 1 0 1234", bus.vram_sel, bus.vram_wr, bus.vram_addr);
    end
    $display("host read 1234 issued, expect BEEF");
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    set_in(0, 0, 1, 1, 16'h0010, 16'hA5A5, 0, 0, 0, 0);
    @(negedge clk);
    vectors++;
    if (bus.host_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ack0: got %b, want 1", bus.host_ack);
    end
    ref_mem[16'h0010] = 16'hA5A5;
    tick();
    set_in(0, 0, 1, 0, 16'h0010, 0, 0, 0, 0, 0);
    @(negedge clk);
    vectors++;
    if (bus.host_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ack1: got %b, want 1", bus.host_ack);
    end
    sb_push(3'b010, 16'h0010);
    vectors++;
    if (bus.vram_wr !== 1'b1 || bus.vram_addr !== 16'h0010 || bus.vram_wr_data !== 16'hA5A5) begin
      miscompares++;
      $display("FAIL b2b_write_cmd: got wr %b addr %h wdata %h, want 1 0010 a5a5", bus.vram_wr, bus.vram_addr, bus.vram_wr_data);
    end
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    vectors++;
    if (bus.vram_sel !== 1'b1 || bus.vram_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_read_cmd: got sel %b wr %b, want 1 0", bus.vram_sel, bus.vram_wr);
    end
    $display("host write/read 0010 back-to-back issued");
    repeat (3) tick();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.vram_sel !== 1'b0 || bus.vram_wr !== 1'b0 || bus.host_ack !== 1'b0 ||
          bus.blit_ack !== 1'b0 || bus.vram_addr !== 16'h0010) begin
        miscompares++;
        $display("FAIL idle[%0d]: got sel %b wr %b hack %b back %b addr %h, want 0 0 0 0 0010", i, bus.vram_sel, bus.vram_wr, bus.host_ack, bus.blit_ack, bus.vram_addr);
      end
      tick();
    end
    $display("idle 16 cycles done");
  endtask

  task automatic test_vgen();
    // Phase A: video owns the port, host held off until video drops.
    for (int i = 0; i < 5; i++) begin
      set_in(i < 4, 16'(i), 1, 0, 16'h3000, 0, 0, 0, 0, 0);
      @(negedge clk);
      vectors++;
      if (bus.host_ack !== (i == 4)) begin
        miscompares++;
        $display("FAIL vgen_host_ack[%0d]: got %b, want %b", i, bus.host_ack, (i == 4));
      end
      if (i < 4) sb_push(3'b100, 16'(i));
      else       sb_push(3'b010, 16'h3000);
      tick();
    end
    // Phase B: blit blocked by video for 8 cycles becomes starved and beats host.
    for (int i = 0; i < 10; i++) begin
      set_in(i < 8, 16'(i), 1, 0, 16'h3000, 0, i < 9, 0, 16'h0002, 0);
      @(negedge clk);
      vectors++;
      if (bus.host_ack !== (i == 9) || bus.blit_ack !== (i == 8)) begin
        miscompares++;
        $display("FAIL vgen_all_ack[%0d]: got host %b blit %b, want %b %b", i, bus.host_ack, bus.blit_ack, (i == 9), (i == 8));
      end
      if (i < 8)       sb_push(3'b100, 16'(i));
      else if (i == 8) sb_push(3'b001, 16'h0002);
      else             sb_push(3'b010, 16'h3000);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("vgen priority sequence done");
    repeat (3) tick();
  endtask

  task automatic test_starve();
    for (int i = 0; i < 27; i++) begin
      set_in(0, 0, 1, 0, 16'h3000, 0, 1, 1, 16'h2000 + 16'(i), 16'h0100 + 16'(i));
      @(negedge clk);
      vectors++;
      if (bus.host_ack !== (i % 9 != 8) || bus.blit_ack !== (i % 9 == 8)) begin
        miscompares++;
        $display("FAIL starve_slot[%0d]: got host %b blit %b, want %b %b", i, bus.host_ack, bus.blit_ack, (i % 9 != 8), (i % 9 == 8));
      end
      if (i % 9 == 8) ref_mem[16'h2000 + 16'(i)] = 16'h0100 + 16'(i);
      else            sb_push(3'b010, 16'h3000);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("starvation 27 slots done");
    repeat (3) tick();
  endtask

  task automatic test_reset_pulse();
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 16'h0005, 0);
    @(negedge clk);
    vectors++;
    if (bus.blit_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_blit_ack: got %b, want 1", bus.blit_ack);
    end
    tick();
    reset_n = 1'b0;
    sb.delete();
    set_in(0, 0, 1, 1, 16'h0005, 16'hDEAD, 1, 1, 16'h0005, 16'hDEAD);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.vram_sel !== 1'b0 || bus.vram_wr !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_cmd[%0d]: got sel %b wr %b, want 0 0", i, bus.vram_sel, bus.vram_wr);
      end
      tick();
    end
    reset_n = 1'b1;
    // A cleared wait counter means exactly eight host slots before blit wins.
    for (int i = 0; i < 9; i++) begin
      set_in(0, 0, 1, 0, 16'h3000, 0, 1, 0, 16'h0005, 0);
      @(negedge clk);
      vectors++;
      if (bus.host_ack !== (i != 8) || bus.blit_ack !== (i == 8)) begin
        miscompares++;
        $display("FAIL rst_counter_slot[%0d]: got host %b blit %b, want %b %b", i, bus.host_ack, bus.blit_ack, (i != 8), (i == 8));
      end
      if (i == 8) sb_push(3'b001, 16'h0005);
      else        sb_push(3'b010, 16'h3000);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("reset pulse sequence done");
    repeat (4) tick();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      vram_mem[i] = 16'h1000 + 16'(i);
      ref_mem[i]  = 16'h1000 + 16'(i);
    end
    vram_mem[16'h1234] = 16'hBEEF;  ref_mem[16'h1234] = 16'hBEEF;
    vram_mem[16'h3000] = 16'hC0DE;  ref_mem[16'h3000] = 16'hC0DE;
    vram_mem[16'h0005] = 16'h5555;  ref_mem[16'h0005] = 16'h5555;

    test_reset();
    test_host_read();
    test_back_to_back();
    test_idle();
    test_vgen();
    test_starve();
    test_reset_pulse();

    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at cycle %0d, want completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vram_arb.md
Name: vram_arb

Overview:
- Single-port VRAM arbiter: shares the 64K x 16 VRAM between three requesters.
  - Video generator (vgen): fixed latency, never stalled.
  - Host register interface (host).
  - Blitter (blit).
- Registers one command per cycle onto the VRAM port and steers returned read data to its owner.
- Sits between the requesters and the VRAM instance at the top of the Xosera core.

Parameters:
- BLIT_STARVE_MAX, 8, cycles blit may wait while blocked by host before it gains priority over host; legal range 1..255.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- vgen_sel  in  1  video read request this cycle; no handshake, always granted
- vgen_addr  in  16  video read address
- vgen_rd_valid  out  1  video read data valid on rd_data
- host_req  in  1  host request (held until ack)
- host_wr  in  1  1=write, 0=read
- host_addr  in  16  host address
- host_wr_data  in  16  host write data
- host_ack  out  1  combinational accept; transfer occurs when host_req & host_ack
- host_rd_valid  out  1  host read data valid on rd_data
- blit_req, blit_wr, blit_addr[16], blit_wr_data[16], blit_ack, blit_rd_valid  same semantics as host
- rd_data  out  16  passthrough of vram_data_out
- vram_sel  out  1  registered VRAM select
- vram_wr  out  1  registered VRAM write enable
- vram_addr  out  16  registered VRAM address
- vram_wr_data  out  16  registered VRAM write data
- vram_data_out  in  16  VRAM read data; valid the cycle after vram_sel read cycle

Behaviour:
- Arbitration (combinational, cycle k), priority order:
  1. vgen_sel wins always.
  2. Else blit, if blit_starved (wait counter == BLIT_STARVE_MAX) and blit_req.
  3. Else host, if host_req.
  4. Else blit, if blit_req.
  5. Else idle.
- Acks:
  - host_ack = host granted; blit_ack = blit granted.
  - Ack may depend on own req; requesters must not make req depend on ack.
  - Back-to-back acks to the same requester are permitted (1 access/cycle).
- Command register (edge k+1):
  - vram_sel = 1 if any grant.
  - vram_wr = granted wr (0 for vgen).
  - vram_addr and vram_wr_data = granted values.
  - When idle: vram_sel=0, vram_wr=0, addr/data hold their last value.
- Read tag pipeline:
  - 2-bit owner tag registered with the command (edge k+1), registered again (edge k+2).
  - In cycle k+2 exactly one of vgen/host/blit_rd_valid is 1 for a read grant; rd_data = vram_data_out.
  - Writes produce no rd_valid.
  - Read latency: req/ack cycle k -> data cycle k+2, fixed for all requesters.
- Starvation counter:
  - Increments while blit_req & ~blit_ack; saturates at BLIT_STARVE_MAX.
  - Clears on blit_ack or ~blit_req.
  - Cycles lost to vgen count.
  - Width = clog2(BLIT_STARVE_MAX+1).
- Simultaneous events:
  - vgen+host+blit: vgen granted, both acks 0.
  - host+blit not starved: host granted.
  - host+blit starved: blit granted, counter clears, host waits one cycle.
- Reset (async, any time):
  - All registered outputs 0: vram_sel, vram_wr, vram_addr, vram_wr_data, all rd_valid.
  - Tags cleared to NONE, counter 0.
  - In-flight reads are dropped with no rd_valid.
  - No VRAM write is possible while reset_n=0.
- Acks are combinational, so they follow req during reset; requester logic is also held in reset.

Decomposition:
- Shared package xosera_pkg: owner tag constants TAG_NONE=2'd0, TAG_VGEN=2'd1, TAG_HOST=2'd2, TAG_BLIT=2'd3.
- No sub-module; arbitration, command register, tag pipeline and counter are inline.

Test Plan:
- Host read 0x1234 alone (VRAM[0x1234]=0xBEEF) -> host_ack cycle 0; vram_sel=1, addr=0x1234 cycle 1; host_rd_valid=1, rd_data=0xBEEF cycle 2; no other valid.
- Host write 0x0010<=0xA5A5 then read 0x0010 back-to-back -> acks cycles 0,1; vram_wr 1 then 0; host_rd_valid cycle 3 with 0xA5A5.
- vgen_sel every cycle, addr 0..7 with host_req held -> host_ack never 1; vgen_rd_valid 2 cycles after each; drop vgen_sel -> host acked next cycle.
- host_req and blit_req held continuously, BLIT_STARVE_MAX=8 -> 8 host acks, then 1 blit ack, repeating (blit gets 1 of every 9 slots).
- Blit read issued, reset_n pulsed low in cycle 1 -> no blit_rd_valid; vram_sel=0 during reset; counter 0 after release.
- No requests -> vram_sel=0, vram_wr=0, all acks and rd_valid 0 for 16 cycles.
